// File: rtl/round_robin_arbiter.sv
// Rotating-priority arbiter: one-hot grant, binary index and valid/ready transfer handshake.
// Optional ARB_LOCK_EN adds a lock input that holds the grant on its owner across transfers.
module round_robin_arbiter #(
   parameter int p_width = 4,
   parameter int p_mode  = 1,
   localparam int IW     = (p_width > 1) ? $clog2(p_width) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [p_width-1:0] req,
   output logic [p_width-1:0] gnt,
   output logic [IW-1:0]      gnt_idx,
   output logic               gnt_val,
   input  logic               gnt_rdy
`ifdef ARB_LOCK_EN
   ,
   input  logic               lock
`endif
);

   localparam logic [p_width-1:0] PTR_RST = p_width'(1);

   logic [p_width-1:0] ptr_q, ptr_d;
   logic [p_width-1:0] pick;
   logic [p_width-1:0] rot;
   logic               xfer;

   // Scan upward from the pointer position, wrapping at the top.
   always_comb begin : sel
      int base;
      int j;
      logic hit;
      base = 0;
      j    = 0;
      hit  = 1'b0;
      pick = '0;
      for (int i = 0; i < p_width; i++)
         if (ptr_q[i]) base = i;
      for (int k = 0; k < p_width; k++) begin
         j = base + k;
         if (j >= p_width) j = j - p_width;
         if (!hit && req[j]) begin
            pick[j] = 1'b1;
            hit     = 1'b1;
         end
      end
   end

`ifdef ARB_LOCK_EN
   logic               locked_q, locked_d;
   logic [p_width-1:0] owner_q, owner_d;

   assign gnt = locked_q ? (owner_q & req) : pick;
`else
   assign gnt = pick;
`endif

   assign gnt_val = |gnt;
   assign xfer    = gnt_val & gnt_rdy;

   always_comb begin
      rot     = '0;
      gnt_idx = '0;
      for (int i = 0; i < p_width; i++) begin
         rot[(i + 1) % p_width] = gnt[i];
         if (gnt[i]) gnt_idx = IW'(i);
      end
   end

   always_comb begin
      ptr_d = ptr_q;
`ifdef ARB_LOCK_EN
      locked_d = locked_q;
      owner_d  = owner_q;
      if (locked_q) begin
         if (xfer && !lock) begin
            locked_d = 1'b0;
            ptr_d    = rot;
         end else if (~|(req & owner_q)) begin
            locked_d = 1'b0;
         end
      end else if (xfer) begin
         if (lock) begin
            locked_d = 1'b1;
            owner_d  = gnt;
         end else begin
            ptr_d = rot;
         end
      end
`else
      if (xfer) ptr_d = rot;
`endif
      // Fixed-priority mode keeps bit 0 on top regardless of transfers.
      if (p_mode == 0) ptr_d = PTR_RST;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q    <= PTR_RST;
`ifdef ARB_LOCK_EN
         locked_q <= 1'b0;
         owner_q  <= '0;
`endif
      end else begin
         ptr_q    <= ptr_d;
`ifdef ARB_LOCK_EN
         locked_q <= locked_d;
         owner_q  <= owner_d;
`endif
      end
   end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: widths 4 (both modes), 8, 32 and 1 against a rotating-priority model.
module tb_round_robin_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic gnt_rdy = 1'b0;
`ifdef ARB_LOCK_EN
   logic lock = 1'b0;
`endif
   logic [3:0]  req4  = '0;
   logic [7:0]  req8  = '0;
   logic [31:0] req32 = '0;
   logic [0:0]  req1  = '0;

   logic [3:0]  g4, g4f;
   logic [1:0]  i4, i4f;
   logic        v4, v4f;
   logic [7:0]  g8;
   logic [2:0]  i8;
   logic        v8;
   logic [31:0] g32;
   logic [4:0]  i32;
   logic        v32;
   logic [0:0]  g1, i1;
   logic        v1;

   always #5 clk = ~clk;

   round_robin_arbiter #(.p_width(4), .p_mode(1)) u4 (
      .clk(clk), .rst(rst), .req(req4), .gnt(g4), .gnt_idx(i4), .gnt_val(v4), .gnt_rdy(gnt_rdy)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );
   round_robin_arbiter #(.p_width(4), .p_mode(0)) u4f (
      .clk(clk), .rst(rst), .req(req4), .gnt(g4f), .gnt_idx(i4f), .gnt_val(v4f), .gnt_rdy(gnt_rdy)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );
   round_robin_arbiter #(.p_width(8), .p_mode(1)) u8 (
      .clk(clk), .rst(rst), .req(req8), .gnt(g8), .gnt_idx(i8), .gnt_val(v8), .gnt_rdy(gnt_rdy)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );
   round_robin_arbiter #(.p_width(32), .p_mode(1)) u32 (
      .clk(clk), .rst(rst), .req(req32), .gnt(g32), .gnt_idx(i32), .gnt_val(v32), .gnt_rdy(gnt_rdy)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );
   round_robin_arbiter #(.p_width(1), .p_mode(1)) u1 (
      .clk(clk), .rst(rst), .req(req1), .gnt(g1), .gnt_idx(i1), .gnt_val(v1), .gnt_rdy(gnt_rdy)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );

   // Model state per instance: priority position, lock flag, owner position.
   int W[5] = '{4, 4, 8, 32, 1};
   int M[5] = '{1, 0, 1, 1, 1};
   int mptr[5];
   int mown[5];
   bit mlk[5];

   int checks = 0;
   int errors = 0;

   bit         lit_en[2];
   logic [3:0] lit_g[2];
   string      lit_name = "";
   event       lit_ev;

   function automatic logic [31:0] rq(int n);
      case (n)
         0, 1:    return {28'b0, req4};
         2:       return {24'b0, req8};
         3:       return req32;
         default: return {31'b0, req1};
      endcase
   endfunction

   // Winning position, or -1 when nobody may be granted.
   function automatic int pick(int n);
      logic [31:0] r;
      int i;
      r = rq(n);
      if (mlk[n]) return r[mown[n]] ? mown[n] : -1;
      for (int k = 0; k < W[n]; k++) begin
         i = (mptr[n] + k) % W[n];
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] idx_of(logic [3:0] oh);
      for (int i = 0; i < 4; i++)
         if (oh[i]) return 32'(i);
      return 32'd0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 5; n++) begin
            mptr[n] = 0;
            mlk[n]  = 1'b0;
            mown[n] = 0;
         end
      end else begin
         for (int n = 0; n < 5; n++) begin
            int g;
            bit xf, lk;
            logic [31:0] r;
            int nxt;
            r   = rq(n);
            g   = pick(n);
            xf  = (g >= 0) && gnt_rdy;
            nxt = (M[n] == 1) ? (g + 1) % W[n] : 0;
`ifdef ARB_LOCK_EN
            lk = lock;
`else
            lk = 1'b0;
`endif
            if (mlk[n]) begin
               if (xf && !lk) begin
                  mlk[n]  = 1'b0;
                  mptr[n] = nxt;
               end else if (!r[mown[n]]) begin
                  mlk[n] = 1'b0;
               end
            end else if (xf) begin
               if (lk) begin
                  mlk[n]  = 1'b1;
                  mown[n] = g;
               end else begin
                  mptr[n] = nxt;
               end
            end
         end
      end
   end

   // Single checker: model comparison on every negedge, plus any pinned literal expectations.
   always begin
      @(negedge clk or lit_ev);
      for (int n = 0; n < 5; n++) begin
         int g;
         logic [31:0] eg, ei, dg, di;
         logic ev, dv;
         g  = pick(n);
         eg = (g < 0) ? 32'd0 : (32'd1 << g);
         ei = (g < 0) ? 32'd0 : 32'(g);
         ev = (g >= 0);
         case (n)
            0:       begin dg = {28'b0, g4};  di = {30'b0, i4};  dv = v4;  end
            1:       begin dg = {28'b0, g4f}; di = {30'b0, i4f}; dv = v4f; end
            2:       begin dg = {24'b0, g8};  di = {29'b0, i8};  dv = v8;  end
            3:       begin dg = g32;          di = {27'b0, i32}; dv = v32; end
            default: begin dg = {31'b0, g1};  di = {31'b0, i1};  dv = v1;  end
         endcase
         checks++;
         if (dg !== eg || di !== ei || dv !== ev) begin
            errors++;
            $display("FAIL model w%0d/m%0d t=%0t: got gnt=%h idx=%0d val=%b, expected gnt=%h idx=%0d val=%b",
                     W[n], M[n], $time, dg, di, dv, eg, ei, ev);
         end
      end
      for (int l = 0; l < 2; l++) begin
         if (lit_en[l]) begin
            logic [3:0] dg;
            logic [31:0] di;
            logic dv;
            dg = (l == 0) ? g4 : g4f;
            di = (l == 0) ? {30'b0, i4} : {30'b0, i4f};
            dv = (l == 0) ? v4 : v4f;
            checks++;
            if (dg !== lit_g[l] || di !== idx_of(lit_g[l]) || dv !== (|lit_g[l])) begin
               errors++;
               $display("FAIL %s mode%0d t=%0t: got gnt=%b idx=%0d val=%b, expected gnt=%b idx=%0d val=%b",
                        lit_name, 1 - l, $time, dg, di, dv, lit_g[l], idx_of(lit_g[l]), |lit_g[l]);
            end
         end
      end
   end

   // Called just after a posedge; the following negedge checks the expectations.
   task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] e_rr,
                       input logic [3:0] e_fx, input string nm);
      req4      = r;
      gnt_rdy   = rdy;
      lit_en[0] = 1'b1;
      lit_en[1] = 1'b1;
      lit_g[0]  = e_rr;
      lit_g[1]  = e_fx;
      lit_name  = nm;
      @(posedge clk);
      #1;
   endtask

   initial begin
      lit_en[0] = 1'b1;
      lit_en[1] = 1'b1;
      lit_g[0]  = 4'b0000;
      lit_g[1]  = 4'b0000;
      lit_name  = "reset_idle";
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "rr0");
      step(4'b1111, 1'b1, 4'b0010, 4'b0001, "rr1");
      step(4'b1111, 1'b1, 4'b0100, 4'b0001, "rr2");
      step(4'b1111, 1'b1, 4'b1000, 4'b0001, "rr3");
      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "rr4");
      step(4'b1111, 1'b1, 4'b0010, 4'b0001, "rr5");
      step(4'b1111, 1'b1, 4'b0100, 4'b0001, "rr6");
      step(4'b1111, 1'b1, 4'b1000, 4'b0001, "rr7");
      step(4'b1001, 1'b1, 4'b0001, 4'b0001, "wrap");
      step(4'b1001, 1'b1, 4'b1000, 4'b0001, "wrap2");
      for (int s = 0; s < 3; s++)
         step(4'b0110, 1'b0, 4'b0010, 4'b0010, "stall");
      step(4'b0110, 1'b1, 4'b0010, 4'b0010, "stall_go");
      step(4'b0110, 1'b1, 4'b0100, 4'b0010, "after_stall");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "idle_rdy");
      step(4'b1111, 1'b0, 4'b1000, 4'b0001, "hold");
      step(4'b1110, 1'b1, 4'b1000, 4'b0010, "pe1");
      step(4'b1110, 1'b1, 4'b0010, 4'b0010, "pe2");
      step(4'b0010, 1'b1, 4'b0010, 4'b0010, "pre_rst");

      // Reset asserted between edges must take effect without a clock.
      req4    = 4'b1111;
      gnt_rdy = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      lit_g[0] = 4'b0001;
      lit_g[1] = 4'b0001;
      lit_name = "async_rst";
      ->lit_ev;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "post_rst");

      lit_en[0] = 1'b0;
      lit_en[1] = 1'b0;
      for (int s = 0; s < 20; s++) begin
         req4    = 4'($urandom);
         req8    = (s % 5 == 4) ? 8'($urandom & $urandom) : 8'($urandom);
         req32   = (s % 4 == 3) ? ($urandom & $urandom & $urandom) : $urandom;
         req1    = 1'($urandom);
         gnt_rdy = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end

`ifdef ARB_LOCK_EN
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "lk_a");
      step(4'b1111, 1'b1, 4'b0010, 4'b0001, "lk_b");
      lock = 1'b1;
      step(4'b1111, 1'b1, 4'b0100, 4'b0001, "lk_set");
      step(4'b1111, 1'b1, 4'b0100, 4'b0001, "lk_hold1");
      step(4'b1111, 1'b0, 4'b0100, 4'b0001, "lk_hold2");
      lock = 1'b0;
      step(4'b1111, 1'b1, 4'b0100, 4'b0001, "lk_rel");
      step(4'b1111, 1'b1, 4'b1000, 4'b0001, "lk_after");
      lock = 1'b1;
      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "lk_set2");
      lock = 1'b0;
      step(4'b1110, 1'b0, 4'b0000, 4'b0000, "lk_mask");
      step(4'b1110, 1'b0, 4'b0010, 4'b0010, "lk_drop");
`endif

      lit_en[0] = 1'b0;
      lit_en[1] = 1'b0;
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
